// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: memory-wait FSM states and
// operand forwarding select codes.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one Execute operand.
// The Memory stage holds the younger result, so it wins over Writeback.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       regWriteM,
    input  logic       regWriteW,
    output logic [1:0] fwd
);

    logic hitM;
    logic hitW;

    assign hitM = regWriteM & (rdM != 5'd0) & (rdM == rsE);
    assign hitW = regWriteW & (rdW != 5'd0) & (rdW == rsE);

    always_comb begin
        fwd = FWD_RF;
        priority case (1'b1)
            hitM:    fwd = FWD_MEM;
            hitW:    fwd = FWD_WB;
            default: fwd = FWD_RF;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: stall/flush enables, forwarding selects,
// data-memory wait FSM with timeout and saturating perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             PCSrcE,
    input  logic             ResultSrcEb0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             DMemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] LoadUseCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] MemWaitCnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic              lwStall;
    logic              memStall;
    logic              timeoutHit;

    fwd_sel uFwdA (
        .rsE       (Rs1E),
        .rdM       (RdM),
        .rdW       (RdW),
        .regWriteM (RegWriteM),
        .regWriteW (RegWriteW),
        .fwd       (ForwardAE)
    );

    fwd_sel uFwdB (
        .rsE       (Rs2E),
        .rdM       (RdM),
        .rdW       (RdW),
        .regWriteM (RegWriteM),
        .regWriteW (RegWriteW),
        .fwd       (ForwardBE)
    );

    assign lwStall = ResultSrcEb0 & (RdE != 5'd0)
                   & ((RdE == Rs1D) | (RdE == Rs2D));

    always_comb begin
        stateNext  = state;
        memStall   = 1'b0;
        timeoutHit = 1'b0;
        unique case (state)
            RUN: begin
                memStall = MemReqM & ~DMemReadyM;
                if (memStall) stateNext = MEM_WAIT;
            end
            MEM_WAIT: begin
                // A timed-out access is abandoned, releasing the pipeline
                timeoutHit = ~DMemReadyM
                           & (waitCnt == WAIT_W'(TIMEOUT - 1));
                memStall   = ~DMemReadyM & ~timeoutHit;
                if (DMemReadyM | timeoutHit) stateNext = RUN;
            end
        endcase
    end

    assign StallF = lwStall | memStall;
    assign StallD = lwStall | memStall;
    assign StallE = memStall;
    assign StallM = memStall;
    assign FlushW = memStall;
    assign FlushD = PCSrcE & ~memStall;
    assign FlushE = (lwStall | PCSrcE) & ~memStall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            waitCnt    <= '0;
            MemErr     <= 1'b0;
            LoadUseCnt <= '0;
            FlushCnt   <= '0;
            MemWaitCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == RUN) waitCnt <= '0;
            else              waitCnt <= waitCnt + WAIT_W'(1);
            if (timeoutHit) MemErr <= 1'b1;
            if (lwStall & ~memStall & (LoadUseCnt != CNT_MAX))
                LoadUseCnt <= LoadUseCnt + CNT_W'(1);
            if (PCSrcE & ~memStall & (FlushCnt != CNT_MAX))
                FlushCnt <= FlushCnt + CNT_W'(1);
            if (memStall & (MemWaitCnt != CNT_MAX))
                MemWaitCnt <= MemWaitCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random
// stimulus against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic pcSrc, ld, rwM, rwW, req, rdy, rstn;
    } stim_t;

    typedef struct {
        int cyc;
        int stalls;
        int flushes;
        int fwd;
        int err;
        int lu;
        int fl;
        int mw;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [4:0]       Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
    logic [4:0]       RdE = '0, RdM = '0, RdW = '0;
    logic             PCSrcE = 1'b0, ResultSrcEb0 = 1'b0;
    logic             RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic             MemReqM = 1'b0, DMemReadyM = 1'b0;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] LoadUseCnt, FlushCnt, MemWaitCnt;

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .PCSrcE(PCSrcE), .ResultSrcEb0(ResultSrcEb0),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .DMemReadyM(DMemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr),
        .LoadUseCnt(LoadUseCnt), .FlushCnt(FlushCnt), .MemWaitCnt(MemWaitCnt)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state: is an access outstanding, how long it has
    // waited, sticky error, and the three event tallies.
    bit   mWaiting = 0;
    int   mWaited  = 0;
    bit   mErr     = 0;
    int   mLu = 0, mFl = 0, mMw = 0;

    function automatic int fwdOf(logic [4:0] rs, logic [4:0] rdM,
                                 logic [4:0] rdW, logic wM, logic wW);
        if (wM && rdM != 0 && rdM == rs) return 2;
        if (wW && rdW != 0 && rdW == rs) return 1;
        return 0;
    endfunction

    function automatic int sat(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rs1D = 0; s.rs2D = 0; s.rs1E = 0; s.rs2E = 0;
        s.rdE = 0; s.rdM = 0; s.rdW = 0;
        s.pcSrc = 0; s.ld = 0; s.rwM = 0; s.rwW = 0;
        s.req = 0; s.rdy = 0; s.rstn = 1;
        return s;
    endfunction

    task automatic check(string nm, int cyc, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic drive(stim_t s);
        exp_t e;
        bit   lw, ms, tmo;
        @(negedge clk);
        cycle++;
        Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E;
        RdE = s.rdE; RdM = s.rdM; RdW = s.rdW;
        PCSrcE = s.pcSrc; ResultSrcEb0 = s.ld;
        RegWriteM = s.rwM; RegWriteW = s.rwW;
        MemReqM = s.req; DMemReadyM = s.rdy; reset_n = s.rstn;
        if (!s.rstn) begin
            mWaiting = 0; mWaited = 0; mErr = 0;
            mLu = 0; mFl = 0; mMw = 0;
        end
        lw  = s.ld && s.rdE != 0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
        tmo = mWaiting && !s.rdy && (mWaited == TIMEOUT - 1);
        ms  = mWaiting ? (!s.rdy && !tmo) : (s.req && !s.rdy);
        e.cyc     = cycle;
        e.stalls  = {2'(lw || ms) == 0 ? 2'b00 : 2'b11, ms, ms};
        e.flushes = {s.pcSrc && !ms, (lw || s.pcSrc) && !ms, ms};
        e.fwd     = fwdOf(s.rs1E, s.rdM, s.rdW, s.rwM, s.rwW) * 4
                  + fwdOf(s.rs2E, s.rdM, s.rdW, s.rwM, s.rwW);
        e.err = mErr;
        e.lu  = mLu;
        e.fl  = mFl;
        e.mw  = mMw;
        q.push_back(e);
        if (s.rstn) begin
            if (lw && !ms)      mLu = sat(mLu + 1);
            if (s.pcSrc && !ms) mFl = sat(mFl + 1);
            if (ms)             mMw = sat(mMw + 1);
            if (tmo)            mErr = 1;
            if (!mWaiting) begin
                if (s.req && !s.rdy) begin
                    mWaiting = 1;
                    mWaited  = 0;
                end
            end else if (s.rdy || tmo) begin
                mWaiting = 0;
            end else begin
                mWaited++;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("stalls", e.cyc,
                      int'({StallF, StallD, StallE, StallM}), e.stalls);
                check("flushes", e.cyc,
                      int'({FlushD, FlushE, FlushW}), e.flushes);
                check("forward", e.cyc,
                      int'({ForwardAE, ForwardBE}), e.fwd);
                check("memErr", e.cyc, int'(MemErr), e.err);
                check("loadUseCnt", e.cyc, int'(LoadUseCnt), e.lu);
                check("flushCnt", e.cyc, int'(FlushCnt), e.fl);
                check("memWaitCnt", e.cyc, int'(MemWaitCnt), e.mw);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        s = idle(); s.rstn = 0;
        drive(s); drive(s);
        s = idle(); drive(s);

        s = idle(); s.rdM = 5; s.rdW = 5; s.rs1E = 5; s.rwM = 1; s.rwW = 1;
        drive(s);
        s.rwM = 0; drive(s);
        s.rs1E = 0; drive(s);

        s = idle(); s.ld = 1; s.rdE = 7; s.rs2D = 7; drive(s);
        s = idle(); drive(s);
        s.ld = 1; s.rdE = 0; s.rs2D = 0; drive(s);
        s = idle(); drive(s);

        s = idle(); s.pcSrc = 1; drive(s);
        s = idle(); drive(s);

        s = idle(); s.req = 1; s.pcSrc = 1;
        repeat (3) drive(s);
        s.rdy = 1; drive(s);
        s = idle(); drive(s); drive(s);

        s = idle(); s.rstn = 0; drive(s);
        s = idle(); s.req = 1; drive(s);
        s.req = 0;
        repeat (5) drive(s);
        s = idle(); repeat (3) drive(s);
        s.rstn = 0; drive(s);
        s.rstn = 1; drive(s);

        s = idle(); s.req = 1; drive(s); drive(s);
        s.req = 0; s.rstn = 0; drive(s);
        s.rstn = 1; drive(s);

        s = idle(); s.ld = 1; s.rdE = 3; s.rs1D = 3;
        repeat (5) drive(s);
        s = idle(); drive(s);

        repeat (600) begin
            s.rs1D  = 5'($urandom_range(0, 3));
            s.rs2D  = 5'($urandom_range(0, 3));
            s.rs1E  = 5'($urandom_range(0, 3));
            s.rs2E  = 5'($urandom_range(0, 3));
            s.rdE   = 5'($urandom_range(0, 3));
            s.rdM   = 5'($urandom_range(0, 3));
            s.rdW   = 5'($urandom_range(0, 3));
            s.pcSrc = ($urandom_range(0, 3) == 0);
            s.ld    = $urandom_range(0, 1) == 1;
            s.rwM   = $urandom_range(0, 1) == 1;
            s.rwW   = $urandom_range(0, 1) == 1;
            s.req   = $urandom_range(0, 1) == 1;
            s.rdy   = ($urandom_range(0, 9) < 3);
            s.rstn  = ($urandom_range(0, 39) != 0);
            drive(s);
        end

        @(negedge clk);
        @(negedge clk);
        check("queueDrained", cycle, q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer end of the pipeline control signals produced in Decode/Execute/Memory/Writeback: RegWriteM, RegWriteW, ResultSrcEb0 and PCSrcE.
- Generates per-stage stall/flush enables and Execute-stage operand forwarding selects.
- Owns the variable-latency data-memory wait handshake through a small FSM with a timeout.
- Keeps saturating performance counters for load-use stalls, control flushes and memory-wait cycles.

Parameters:
- CNT_W, 16, width of each performance counter.
- TIMEOUT, 64, cycles in MEM_WAIT before the sticky timeout error is raised.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- Rs1D, Rs2D  in  5 each  Decode source registers.
- Rs1E, Rs2E, RdE  in  5 each  Execute source and destination registers.
- RdM, RdW  in  5 each  Memory and Writeback destination registers.
- PCSrcE  in  1  branch taken or jump, resolved in Execute.
- ResultSrcEb0  in  1  Execute instruction is a load.
- RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback.
- MemReqM  in  1  Memory-stage instruction accesses data memory.
- DMemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register feeding that stage.
- FlushD, FlushE, FlushW  out  1 each  bubble the register feeding that stage.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
- MemErr  out  1  sticky memory timeout flag.
- LoadUseCnt, FlushCnt, MemWaitCnt  out  CNT_W each  performance counters.

Behaviour:
- Reset, asynchronous, reset_n low:
  - state=RUN, wait counter=0, MemErr=0, all counters=0.
  - Stall/flush/forward outputs are combinational and follow the inputs even while in reset.
- Forwarding, combinational, per operand X in {A,B} with source RsXE:
  - 10 if RegWriteM & RdM!=0 & RdM==RsXE.
  - else 01 if RegWriteW & RdW!=0 & RdW==RsXE.
  - else 00.
  - Memory takes priority over Writeback.
- lwStall = ResultSrcEb0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall = MemReqM & ~DMemReadyM when state=RUN; ~DMemReadyM when state=MEM_WAIT.
- Output equations:
  - StallF = StallD = lwStall | memStall.
  - StallE = StallM = memStall.
  - FlushW = memStall.
  - FlushD = PCSrcE & ~memStall.
  - FlushE = (lwStall | PCSrcE) & ~memStall.
  - memStall has highest priority: no flush is issued while memory is waiting. The redirect is applied on the cycle the access completes, because PCSrcE is held by StallE.
- FSM (state in {RUN, MEM_WAIT}):
  - RUN -> MEM_WAIT when MemReqM & ~DMemReadyM.
  - MEM_WAIT -> RUN when DMemReadyM.
  - MEM_WAIT -> RUN when the wait counter reaches TIMEOUT-1 with no ready; MemErr is set, and the access is abandoned (memStall drops that cycle).
  - MemReqM & DMemReadyM in RUN completes in zero wait cycles and stays in RUN.
- Wait counter: cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle.
- MemErr: sticky until reset.
- Counters, saturating at all-ones, each increments by 1 per cycle:
  - LoadUseCnt when lwStall & ~memStall.
  - FlushCnt when PCSrcE & ~memStall.
  - MemWaitCnt when memStall.
- Register x0 never creates a hazard or a forward.

Decomposition:
- Package hazard_pkg:
  - state enum (RUN, MEM_WAIT).
  - forward codes FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module fwd_sel (one register compare chain producing a 2-bit select), instantiated twice, for A and B.
- Saturating counter logic stays inline.

Test Plan:
- Forward priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01; Rs1E=0 -> 00.
- Load-use: ResultSrcEb0=1, RdE=7, Rs2D=7 for one cycle -> StallF=StallD=FlushE=1, StallE=0, LoadUseCnt 0->1. Repeat with RdE=0 -> no stall.
- Branch flush: PCSrcE=1 with no memory request -> FlushD=FlushE=1, stalls 0, FlushCnt +1.
- Memory wait with simultaneous branch:
  - Stimulus: MemReqM=1, DMemReadyM low 3 cycles, PCSrcE=1 throughout.
  - Waiting cycles: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0.
  - Ready cycle: flushes issue and the FSM returns to RUN.
  - MemWaitCnt=3.
- Timeout: TIMEOUT=4, DMemReadyM held low -> MemErr=1 after 4 MEM_WAIT cycles, FSM in RUN, MemErr stays 1 until reset_n pulses low.
- Async reset mid-wait: drop reset_n in MEM_WAIT without a clock edge -> state RUN and counters 0 immediately. Counter saturation is checked with CNT_W=2: 5 load-use cycles -> LoadUseCnt=3.
